pkt_peak_find: RTL and testbench
================================

// Module: pkt_peak_find
// PURPOSE
//  Downstream consumer of the packet averager in the channel-sounder chain. Scans each tlast-delimited
//  packet of averaged correlation magnitudes and finds the largest sample and its index. After each
//  input packet it emits a 3-word summary packet (peak, index+flags, length) for host-side delay estimation.
// PARAMETERS
//  WIDTH              32  sample/output word width; unsigned magnitudes; must be >= MAX_PKT_SIZE_LOG2+2
//  MAX_PKT_SIZE_LOG2  14  max input packet length is 2**MAX_PKT_SIZE_LOG2 samples
// PORTS
//  clk          in   1                    single clock, all logic
//  reset        in   1                    asynchronous, active-low reset (0 = reset)
//  i_tdata      in   WIDTH                averaged magnitude sample (unsigned)
//  i_tlast      in   1                    last sample of input packet
//  i_tvalid     in   1                    input valid
//  i_tready     out  1                    input ready
//  o_tdata      out  WIDTH                summary word
//  o_tlast      out  1                    asserted on summary word 2
//  o_tvalid     out  1                    output valid
//  o_tready     in   1                    output ready
//  i_threshold  in   WIDTH                detection threshold, sampled on first beat of each packet
// BEHAVIOUR
//  Reset (reset=0, async): state=ST_SCAN, i_tready=1, o_tvalid=0, o_tlast=0, o_tdata=0, all counters/regs 0.
//   Assertion mid-packet or mid-summary discards it; no partial summary after release.
//  States: ST_SCAN -> ST_EMIT0 -> ST_EMIT1 -> ST_EMIT2 -> ST_SCAN.
//  ST_SCAN: i_tready=1, o_tvalid=0. Each beat (i_tvalid&i_tready) at index idx (0-based):
//   - idx==0: peak<=i_tdata, peak_idx<=0, thr<=i_threshold.
//   - idx>0: if i_tdata > peak (strictly) update peak and peak_idx; ties keep the earliest index.
//   - cnt increments; cnt width MAX_PKT_SIZE_LOG2+1.
//   - End of packet = i_tlast beat, or beat with idx==2**MAX_PKT_SIZE_LOG2-1 without i_tlast
//     (forced end, trunc=1). The next beat then starts a new packet at idx 0.
//   - End-of-packet beat is included in peak/cnt and then goes to ST_EMIT0 next cycle.
//  ST_EMITx: i_tready=0, o_tvalid=1 (registered). Advance only on o_tvalid&o_tready; hold data stable while stalled.
//   - word0: peak
//   - word1: {above, trunc, zeros, peak_idx[MAX_PKT_SIZE_LOG2-1:0]}; above=(peak>=thr); above is bit WIDTH-1
//   - word2: packet length (number of samples), zero-extended; o_tlast=1
//  Latency: end-of-packet beat accepted in cycle N -> word0 valid in cycle N+1.
//   Word2 handshake in cycle M -> i_tready=1 in cycle M+1, and o_tvalid=0 unless reset.
//  Throughput: 3 dead input cycles minimum per packet; upstream FIFO absorbs this.
//  Single-sample packet: peak=sample, idx=0, len=1.
//  Comparisons are unsigned; threshold changes mid-packet are ignored until the next packet start.
// TESTING
//  1) Packet of 8 samples [5,9,3,9,1,0,2,7], tlast on 8th, thr=8, o_tready=1
//     -> summary {9, 0x8000_0001, 8}; tlast on word2; word0 appears 1 cycle after input tlast.
//  2) Same packet with thr=10 -> word1=0x0000_0001 (above=0); with thr=9 -> above=1 (>= boundary).
//  3) Single-sample packet [0xFFFF_FFFF] -> {0xFFFF_FFFF, 0x8000_0000 if thr<=max, 1};
//     back-to-back packets -> i_tready low exactly 3 cycles with o_tready=1.
//  4) o_tready held low 10 cycles during word1 -> o_tdata/o_tlast stable;
//     i_tready stays 0 and no input is consumed until word2 handshakes.
//  5) MAX_PKT_SIZE_LOG2=4, 20 samples with no tlast, max at idx 3 -> first summary {.., trunc=1, idx 3, len 16};
//     remaining 4 samples + tlast -> second packet with idx relative to 0, trunc=0.
//  6) Assert reset low during sample 5 of a packet and during word1 of a summary -> o_tvalid=0 immediately.
//     After release, a fresh packet yields a correct summary with no stale peak.

Source files
------------

// File: rtl/pkt_peak_find.sv
// Packet peak finder: tracks the largest sample and its index in each
// tlast-delimited packet, then emits a 3-word summary (peak, index+flags, length).
module pkt_peak_find #(
  parameter int WIDTH             = 32,
  parameter int MAX_PKT_SIZE_LOG2 = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  input  logic [WIDTH-1:0] i_threshold
);

  localparam int IW = MAX_PKT_SIZE_LOG2;
  localparam int CW = MAX_PKT_SIZE_LOG2 + 1;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_EMIT0,
    ST_EMIT1,
    ST_EMIT2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] peak, thr;
  logic [IW-1:0]    peak_idx;
  logic [CW-1:0]    cnt;
  logic             trunc;

  logic [WIDTH-1:0] peak_new;
  logic [IW-1:0]    peak_idx_new;
  logic [IW-1:0]    idx;
  logic             beat, first, eop, adv;

  logic [WIDTH-1:0] word1;
  logic [WIDTH-1:0] o_tdata_nxt;
  logic             o_tvalid_nxt, o_tlast_nxt;

  assign i_tready = (state == ST_SCAN);
  assign beat     = i_tvalid & i_tready;
  assign idx      = cnt[IW-1:0];
  assign first    = (cnt == '0);
  assign eop      = beat & (i_tlast | (&idx));
  assign adv      = o_tvalid & o_tready;

  // Running peak including the current beat; ties keep the earliest index.
  always_comb begin
    peak_new     = peak;
    peak_idx_new = peak_idx;
    if (first) begin
      peak_new     = i_tdata;
      peak_idx_new = '0;
    end else if (i_tdata > peak) begin
      peak_new     = i_tdata;
      peak_idx_new = idx;
    end
  end

  // Summary word 1: above flag in the MSB, truncation flag below it.
  always_comb begin
    word1            = '0;
    word1[WIDTH-1]   = (peak >= thr);
    word1[WIDTH-2]   = trunc;
    word1[IW-1:0]    = peak_idx;
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_SCAN;
    else        state <= state_nxt;
  end

  // Next state and next registered output word.
  always_comb begin
    state_nxt    = state;
    o_tdata_nxt  = o_tdata;
    o_tvalid_nxt = o_tvalid;
    o_tlast_nxt  = o_tlast;
    unique case (state)
      ST_SCAN: begin
        if (eop) begin
          state_nxt    = ST_EMIT0;
          o_tdata_nxt  = peak_new;
          o_tvalid_nxt = 1'b1;
          o_tlast_nxt  = 1'b0;
        end
      end
      ST_EMIT0: begin
        if (adv) begin
          state_nxt   = ST_EMIT1;
          o_tdata_nxt = word1;
        end
      end
      ST_EMIT1: begin
        if (adv) begin
          state_nxt   = ST_EMIT2;
          o_tdata_nxt = WIDTH'(cnt);
          o_tlast_nxt = 1'b1;
        end
      end
      ST_EMIT2: begin
        if (adv) begin
          state_nxt    = ST_SCAN;
          o_tdata_nxt  = '0;
          o_tvalid_nxt = 1'b0;
          o_tlast_nxt  = 1'b0;
        end
      end
      default: state_nxt = ST_SCAN;
    endcase
  end

  // Registered output channel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_tdata  <= '0;
      o_tvalid <= 1'b0;
      o_tlast  <= 1'b0;
    end else begin
      o_tdata  <= o_tdata_nxt;
      o_tvalid <= o_tvalid_nxt;
      o_tlast  <= o_tlast_nxt;
    end
  end

  // Scan datapath; cnt holds the packet length while the summary drains.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak     <= '0;
      peak_idx <= '0;
      thr      <= '0;
      cnt      <= '0;
      trunc    <= 1'b0;
    end else if (beat) begin
      peak     <= peak_new;
      peak_idx <= peak_idx_new;
      cnt      <= cnt + 1'b1;
      if (first) thr   <= i_threshold;
      if (eop)   trunc <= ~i_tlast;
    end else if (state == ST_EMIT2 && adv) begin
      cnt <= '0;
    end
  end

endmodule

// File: tb/tb_pkt_peak_find.sv
// Bench for pkt_peak_find: table of packets with expected summaries,
// scoreboard queue on the output, plus stall/truncation/reset sequences.
module tb_pkt_peak_find;

  localparam int W = 32;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] i_tdata = '0;
  logic         i_tlast = 1'b0;
  logic         i_tvalid = 1'b0;
  logic         i_tready;
  logic [W-1:0] o_tdata;
  logic         o_tlast;
  logic         o_tvalid;
  logic         o_tready = 1'b1;
  logic [W-1:0] i_threshold = '0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  exp_t q[$];

  typedef struct {
    logic [15:0][W-1:0] s;
    int                 n;
    logic [W-1:0]       thr;
    logic [W-1:0]       w0;
    logic [W-1:0]       w1;
    logic [W-1:0]       w2;
  } vec_t;

  vec_t vt[6];

  pkt_peak_find #(
    .WIDTH(W),
    .MAX_PKT_SIZE_LOG2(L)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_tdata(i_tdata),
    .i_tlast(i_tlast),
    .i_tvalid(i_tvalid),
    .i_tready(i_tready),
    .o_tdata(o_tdata),
    .o_tlast(o_tlast),
    .o_tvalid(o_tvalid),
    .o_tready(o_tready),
    .i_threshold(i_threshold)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push3(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c);
    q.push_back('{a, 1'b0});
    q.push_back('{b, 1'b0});
    q.push_back('{c, 1'b1});
  endtask

  // Output monitor: handshake visible at negedge completes on next posedge.
  always @(negedge clk) begin
    if (reset && o_tvalid && o_tready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %h expected none", o_tdata);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_data", o_tdata, e.data);
        chk("out_last", W'(o_tlast), W'(e.last));
      end
    end
  end

  task automatic drive_beat(input logic [W-1:0] d, input logic last,
                            input logic [W-1:0] thr);
    int k;
    i_tdata     = d;
    i_tlast     = last;
    i_threshold = thr;
    i_tvalid    = 1'b1;
    k = 0;
    @(negedge clk);
    while (!i_tready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      checks++;
      errors++;
      $display("FAIL in_timeout: got tready=0 expected 1");
    end
    @(posedge clk);
    #1;
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic count_busy(input int exp);
    int k;
    k = 0;
    while (!i_tready && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("tready_low_cycles", W'(k), W'(exp));
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((q.size() != 0 || !i_tready) && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drain", W'(q.size()), '0);
  endtask

  initial begin
    logic [W-1:0] cap;
    logic [3:0][W-1:0] p;

    for (int i = 0; i < 6; i++) vt[i].s = '0;
    for (int i = 0; i < 3; i++) begin
      vt[i].s[0] = 5; vt[i].s[1] = 9; vt[i].s[2] = 3; vt[i].s[3] = 9;
      vt[i].s[4] = 1; vt[i].s[5] = 0; vt[i].s[6] = 2; vt[i].s[7] = 7;
      vt[i].n = 8; vt[i].w0 = 9; vt[i].w2 = 8;
    end
    vt[0].thr = 8;  vt[0].w1 = 32'h8000_0001;
    vt[1].thr = 10; vt[1].w1 = 32'h0000_0001;
    vt[2].thr = 9;  vt[2].w1 = 32'h8000_0001;
    vt[3].s[0] = 32'hFFFF_FFFF; vt[3].n = 1; vt[3].thr = 32'hFFFF_FFFF;
    vt[3].w0 = 32'hFFFF_FFFF; vt[3].w1 = 32'h8000_0000; vt[3].w2 = 1;
    vt[4].n = 3; vt[4].thr = 1;
    vt[4].w0 = 0; vt[4].w1 = 32'h0000_0000; vt[4].w2 = 3;
    for (int i = 0; i < 16; i++) vt[5].s[i] = W'(i + 1);
    vt[5].n = 16; vt[5].thr = 16;
    vt[5].w0 = 16; vt[5].w1 = 32'h8000_000F; vt[5].w2 = 16;

    #1;
    chk("rst_tready", W'(i_tready), 1);
    chk("rst_tvalid", W'(o_tvalid), 0);
    chk("rst_tlast", W'(o_tlast), 0);
    chk("rst_tdata", o_tdata, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 6; v++) begin
      push3(vt[v].w0, vt[v].w1, vt[v].w2);
      for (int i = 0; i < vt[v].n; i++)
        drive_beat(vt[v].s[i], i == vt[v].n - 1, vt[v].thr);
      chk("latency_w0_valid", W'(o_tvalid), 1);
      chk("latency_w0_data", o_tdata, vt[v].w0);
      count_busy(3);
    end

    // Output stall on word1; threshold change mid-packet ignored.
    o_tready = 1'b0;
    push3(9, 32'h8000_0001, 8);
    for (int i = 0; i < 8; i++)
      drive_beat(vt[0].s[i], i == 7, (i == 0) ? 32'd9 : 32'd100);
    o_tready = 1'b1;
    @(posedge clk);
    #1;
    o_tready = 1'b0;
    i_tvalid = 1'b1;
    i_tdata  = 32'h1234;
    cap = o_tdata;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_data", o_tdata, cap);
      chk("stall_last", W'(o_tlast), 0);
      chk("stall_tready", W'(i_tready), 0);
    end
    @(posedge clk);
    #1;
    i_tvalid = 1'b0;
    o_tready = 1'b1;
    wait_drain();

    // Forced end after 16 beats, then a 4-beat tail packet.
    push3(100, 32'hC000_0003, 16);
    push3(60, 32'h0000_0002, 4);
    for (int i = 0; i < 16; i++)
      drive_beat((i == 3) ? 32'd100 : W'(i), 1'b0, 32'd0);
    p[0] = 50; p[1] = 7; p[2] = 60; p[3] = 2;
    for (int i = 0; i < 4; i++)
      drive_beat(p[i], i == 3, 32'd61);
    wait_drain();

    // Reset in the middle of a packet.
    for (int i = 0; i < 5; i++)
      drive_beat(W'(200 + i), 1'b0, 32'd0);
    i_tdata  = 32'd7;
    i_tvalid = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid_pkt_tvalid", W'(o_tvalid), 0);
    chk("rst_mid_pkt_tready", W'(i_tready), 1);
    i_tvalid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;

    // Reset during word1 of a summary.
    q.push_back('{32'd200, 1'b0});
    drive_beat(10, 1'b0, 32'd0);
    drive_beat(200, 1'b0, 32'd0);
    drive_beat(3, 1'b1, 32'd0);
    @(posedge clk);
    #1;
    o_tready = 1'b0;
    chk("pre_rst_w1_valid", W'(o_tvalid), 1);
    reset = 1'b0;
    q.delete();
    #1;
    chk("rst_w1_tvalid", W'(o_tvalid), 0);
    chk("rst_w1_tdata", o_tdata, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    o_tready = 1'b1;
    push3(3, 32'h8000_0000, 3);
    drive_beat(3, 1'b0, 32'd2);
    drive_beat(1, 1'b0, 32'd2);
    drive_beat(2, 1'b1, 32'd2);
    wait_drain();

    repeat (3) @(posedge clk);
    chk("queue_empty", W'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
